stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- P_ST_BITS, 32: data width.
- P_DEPTH, 8: entry count, any value 2..256, not required to be a power of two.
- P_DEPTH_LOG2, 3: pointer width, ceil(log2(P_DEPTH)).
- P_AFULL_TH, 6: almost-full threshold, 1..P_DEPTH.
- P_AEMPTY_TH, 1: almost-empty threshold, 0..P_DEPTH-1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk, in, 1: clock, all state updates on the rising edge.
- rst, in, 1: synchronous active-high reset.
- i_flush, in, 1: synchronous discard of all contents.
- i_snk_data, in, P_ST_BITS: write data.
- i_snk_valid, in, 1: write request.
- o_snk_ready, out, 1: space available.
- o_src_data, out, P_ST_BITS: head-of-queue data.
- o_src_valid, out, 1: head valid.
- i_src_ready, in, 1: consumer accepts the head.
- o_level, out, P_DEPTH_LOG2+1: current occupancy, 0..P_DEPTH.
- o_almost_full, out, 1: o_level >= P_AFULL_TH.
- o_almost_empty, out, 1: o_level <= P_AEMPTY_TH.

Function
REQ-003 Push SHALL occur when i_snk_valid && o_snk_ready; pop SHALL occur when o_src_valid && i_src_ready.
REQ-004 The FIFO SHALL hold all P_DEPTH entries, with no sacrificial slot; full means o_level == P_DEPTH.
REQ-005 o_snk_ready SHALL be !full and o_src_valid SHALL be (o_level != 0); both SHALL be derived from registered state only, never from i_snk_valid or i_src_ready.
REQ-006 o_src_data SHALL be the entry at the read pointer, shown first-word-fall-through: a push into an empty FIFO appears on o_src_data with o_src_valid=1 in the next cycle (1-cycle latency).
REQ-007 o_src_data SHALL remain stable while o_src_valid=1 and no pop occurs.
REQ-008 The write and read pointers SHALL each wrap from P_DEPTH-1 to 0, and SHALL never use modulo-2^n wrap unless P_DEPTH is a power of two.
REQ-009 o_level SHALL be updated as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-010 When full, a simultaneous pop SHALL be accepted and the push SHALL be refused, since ready was 0; o_snk_ready SHALL return to 1 in the next cycle.
REQ-011 When empty, no pop SHALL occur and a push SHALL be accepted; same-cycle pass-through SHALL NOT occur.
REQ-012 o_almost_full and o_almost_empty SHALL be registered or derived from registered o_level, and valid in the same cycle as o_level.
REQ-013 A push attempted while not ready SHALL be ignored, with no state change.
REQ-014 i_flush=1 SHALL set both pointers and o_level to 0 at the clock edge, discarding any same-cycle push and pop; memory contents SHALL be left unchanged.

Reset
REQ-015 rst SHALL take priority over i_flush and all traffic.
REQ-016 When rst=1, the block SHALL set w_ptr=0, r_ptr=0 and o_level=0, giving o_snk_ready=1, o_src_valid=0, o_almost_full=0 and o_almost_empty=1.
REQ-017 o_src_data SHALL be undefined after reset until the first push, and storage SHALL NOT be reset.
REQ-018 Reset asserted mid-transfer SHALL drop all contents, and the first push after reset deassertion SHALL be accepted.

Structure
REQ-019 Shared constants, including the handshake polarity and the clog2 helper used to check P_DEPTH_LOG2, SHALL live in the common define/package file, not in this module.
REQ-020 Storage SHALL be one sub-module, fifo_ram: 1 write port, 1 asynchronous read port, parameters width and depth; pointer, level and flag logic SHALL stay in stream_fifo.
REQ-021 An elaboration-time check SHALL flag P_DEPTH_LOG2 < ceil(log2(P_DEPTH)) and thresholds out of range.

Verification (P_ST_BITS=32, P_DEPTH=5, P_AFULL_TH=4, P_AEMPTY_TH=1)
REQ-022 Fill/drain: push 0xA0..0xA4 with src_ready=0 -> level 1..5; almost_full=1 at level 4; snk_ready=0 at level 5; a 6th push is ignored; draining returns 0xA0..0xA4 in order.
REQ-023 Wrap: perform 12 push/pop pairs with values 1..12, level held between 1 and 2 -> outputs 1..12 in order, and pointers wrap 4->0 at least twice.
REQ-024 Full + simultaneous pop: at level 5, assert valid and ready together -> pop accepted, push refused, level 4, ready=1 next cycle.
REQ-025 Empty push: at level 0, push 0x55 with src_ready=1 -> src_valid=0 in that cycle; next cycle src_valid=1, data 0x55, and it pops; then level 0.
REQ-026 Flush/reset: at level 3, assert i_flush together with push 0x77 -> level 0, src_valid=0, 0x77 discarded; repeat with rst=1 and i_flush=1 -> all flags at reset values.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_pkg
// Description : Shared constants and helpers for the stream FIFO slice:
//               handshake polarity and a ceil(log2) helper used to check
//               pointer widths at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

    // Active level of valid/ready on the streaming handshake
    localparam logic c_HS_ACTIVE = 1'b1;

    // Smallest r such that 2**r >= value (value >= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_if
// Description : Streaming handshake bundle for the FIFO. The slave side is
//               the FIFO itself (accepts on snk, offers on src); the master
//               side is the producer/consumer environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_fifo_if #(
    parameter int ST_BITS = 32
);
    logic [ST_BITS-1:0] snk_data;
    logic               snk_valid;
    logic               snk_ready;
    logic [ST_BITS-1:0] src_data;
    logic               src_valid;
    logic               src_ready;

    modport slave (
        input  snk_data,
        input  snk_valid,
        output snk_ready,
        output src_data,
        output src_valid,
        input  src_ready
    );

    modport master (
        output snk_data,
        output snk_valid,
        input  snk_ready,
        input  src_data,
        input  src_valid,
        output src_ready
    );
endinterface
`default_nettype wire

// File: rtl/stream_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : FIFO storage array, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store data at the write address when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read gives first-word-fall-through at the head
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Synchronous FWFT stream FIFO using all P_DEPTH entries.
//               Pointers wrap at P_DEPTH-1 so any depth works; ready/valid
//               and the almost flags come only from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int P_ST_BITS    = 32,
    parameter int P_DEPTH      = 8,
    parameter int P_DEPTH_LOG2 = 3,
    parameter int P_AFULL_TH   = 6,
    parameter int P_AEMPTY_TH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    stream_fifo_if.slave          bus,
    output logic [P_DEPTH_LOG2:0] o_level,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
);

    localparam int                    c_LAST_I     = P_DEPTH - 1;
    localparam logic [P_DEPTH_LOG2-1:0] c_PTR_LAST = c_LAST_I[P_DEPTH_LOG2-1:0];
    localparam logic [P_DEPTH_LOG2:0] c_LEVEL_FULL = P_DEPTH[P_DEPTH_LOG2:0];
    localparam logic [P_DEPTH_LOG2:0] c_AFULL      = P_AFULL_TH[P_DEPTH_LOG2:0];
    localparam logic [P_DEPTH_LOG2:0] c_AEMPTY     = P_AEMPTY_TH[P_DEPTH_LOG2:0];

    // Parameter sanity checks, reported at elaboration
    if (P_DEPTH_LOG2 < clog2(P_DEPTH)) begin : g_chk_ptr_width
        $error("stream_fifo: P_DEPTH_LOG2=%0d too small for P_DEPTH=%0d", P_DEPTH_LOG2, P_DEPTH);
    end
    if (P_DEPTH < 2 || P_DEPTH > 256) begin : g_chk_depth
        $error("stream_fifo: P_DEPTH=%0d outside 2..256", P_DEPTH);
    end
    if (P_AFULL_TH < 1 || P_AFULL_TH > P_DEPTH) begin : g_chk_afull
        $error("stream_fifo: P_AFULL_TH=%0d outside 1..P_DEPTH", P_AFULL_TH);
    end
    if (P_AEMPTY_TH < 0 || P_AEMPTY_TH > P_DEPTH - 1) begin : g_chk_aempty
        $error("stream_fifo: P_AEMPTY_TH=%0d outside 0..P_DEPTH-1", P_AEMPTY_TH);
    end

    logic [P_DEPTH_LOG2-1:0] r_wptr;
    logic [P_DEPTH_LOG2-1:0] r_rptr;
    logic [P_DEPTH_LOG2:0]   r_level;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_we;
    logic [P_DEPTH_LOG2-1:0] w_wptr_nxt;
    logic [P_DEPTH_LOG2-1:0] w_rptr_nxt;

    assign w_full  = (r_level == c_LEVEL_FULL);
    assign w_empty = (r_level == '0);

    // Handshake qualified only by registered occupancy
    assign w_push = (bus.snk_valid == c_HS_ACTIVE) && !w_full;
    assign w_pop  = (bus.src_ready == c_HS_ACTIVE) && !w_empty;

    // Flush and reset discard a same-cycle push without touching storage
    assign w_we = w_push && !i_flush && !rst;

    // Explicit wrap at P_DEPTH-1 so non-power-of-two depths work
    assign w_wptr_nxt = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;

    // Pointer and occupancy state; reset outranks flush, flush outranks traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    fifo_ram #(
        .WIDTH     (P_ST_BITS),
        .DEPTH     (P_DEPTH),
        .ADDR_BITS (P_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (bus.snk_data),
        .i_raddr (r_rptr),
        .o_rdata (bus.src_data)
    );

    assign bus.snk_ready  = w_full  ? ~c_HS_ACTIVE : c_HS_ACTIVE;
    assign bus.src_valid  = w_empty ? ~c_HS_ACTIVE : c_HS_ACTIVE;
    assign o_level        = r_level;
    assign o_almost_full  = (r_level >= c_AFULL);
    assign o_almost_empty = (r_level <= c_AEMPTY);

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_fifo
// Description : Directed self-checking bench for stream_fifo with a queue
//               scoreboard and a small occupancy model (depth 5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

    localparam int c_DEPTH = 5;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] level;
    logic       afull;
    logic       aempty;

    int m_level;
    logic [31:0] sb[$];
    int total;
    int bad;

    stream_fifo_if #(.ST_BITS(32)) bus ();

    stream_fifo #(
        .P_ST_BITS    (32),
        .P_DEPTH      (c_DEPTH),
        .P_DEPTH_LOG2 (3),
        .P_AFULL_TH   (4),
        .P_AEMPTY_TH  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .bus            (bus.slave),
        .o_level        (level),
        .o_almost_full  (afull),
        .o_almost_empty (aempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check registered outputs against the model, drive one cycle, update model
    task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                         input logic fl, input logic rs);
        logic push;
        logic pop;
        push = v && (m_level != c_DEPTH);
        pop  = r && (m_level != 0);
        chk("level", 32'(level), 32'(m_level));
        chk("almost_full", 32'(afull), 32'(m_level >= 4));
        chk("almost_empty", 32'(aempty), 32'(m_level <= 1));
        chk("snk_ready", 32'(bus.snk_ready), 32'(m_level != c_DEPTH));
        chk("src_valid", 32'(bus.src_valid), 32'(m_level != 0));
        if (m_level != 0) begin
            chk("src_data", bus.src_data, sb[0]);
        end
        bus.snk_valid = v;
        bus.snk_data  = d;
        bus.src_ready = r;
        flush         = fl;
        rst           = rs;
        @(posedge clk);
        #1;
        bus.snk_valid = 1'b0;
        bus.src_ready = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
        if (rs || fl) begin
            sb.delete();
            m_level = 0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                m_level--;
            end
            if (push) begin
                sb.push_back(d);
                m_level++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_level = 0;
        bus.snk_valid = 1'b0;
        bus.snk_data  = '0;
        bus.src_ready = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill with 0xA0..0xA4, sixth push refused, then drain in order
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Wrap: 12 values streamed with occupancy held at 1..2
        cycle(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 12; k++) cycle(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Full plus simultaneous push/pop: pop taken, push refused
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hBB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Push into empty with consumer ready: no pass-through
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Flush with a same-cycle push discards everything
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset together with flush mid-traffic, then first push accepted
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
